// File: rtl/tone_gen_pkg.sv
// Shared constants, mixer helper and channel-action encoding for the
// multi-channel square-wave tone generator.
package tone_gen_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 12;
    localparam int POP_W      = 8;   // widest supported channel count

    // Per-channel update decision, listed in priority order.
    typedef enum logic [1:0] {
        ACT_DISABLE,
        ACT_SYNC,
        ACT_COUNT,
        ACT_RELOAD
    } ch_action_e;

    // Number of set bits; callers zero-extend the wave vector to POP_W.
    function automatic logic [3:0] popcount(input logic [POP_W-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < POP_W; i++) begin
            n += 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tone_channel.sv
// One tone channel: double-buffered half-period register, down-counter and
// square-wave flop. A new period only takes effect at the next reload.
module tone_channel
    import tone_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_hit,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             en,
    input  logic             sync,
    output logic             wave
);

    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] cnt;
    ch_action_e       action;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        action = ACT_RELOAD;
        if (!en)
            action = ACT_DISABLE;
        else if (sync)
            action = ACT_SYNC;
        else if (cnt != '0)
            action = ACT_COUNT;
    end

    // NOTE: the period register is a plain flop bank, so it takes the async reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            shadow <= '0;
        else if (wr_hit)
            shadow <= wr_data;
    end

    // NOTE: non-blocking assignments so reload sees shadow as it was before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else begin
            unique case (action)
                ACT_DISABLE: begin
                    cnt  <= '0;
                    wave <= 1'b0;
                end
                ACT_SYNC: begin
                    cnt  <= shadow;
                    wave <= 1'b0;
                end
                ACT_COUNT: cnt <= cnt - 1'b1;
                ACT_RELOAD: begin
                    cnt  <= shadow;
                    wave <= (shadow != '0) ? ~wave : 1'b0;
                end
            endcase
        end
    end

    // Decrement only ever happens from a non-zero count, so the counter cannot wrap.
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        (action == ACT_COUNT) |=> (cnt == $past(cnt) - 1'b1) && ($past(cnt) != '0));

endmodule

// File: rtl/multi_tone_gen.sv
// N-channel square-wave tone generator: write-address decode, channel array
// and a registered population-count mixer.
module multi_tone_gen
    import tone_gen_pkg::*;
#(
    parameter  int NUM_CH = DEF_NUM_CH,
    parameter  int CNT_W  = DEF_CNT_W,
    localparam int ADDR_W = $clog2(NUM_CH),
    localparam int MIX_W  = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] wave,
    output logic [MIX_W-1:0]  mix
);

    // Addresses at or beyond NUM_CH match no channel and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_hit;
        assign wr_hit = wr_valid && (wr_addr == ADDR_W'(i));

        tone_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_hit  (wr_hit),
            .wr_data (wr_data),
            .en      (ch_en[i]),
            .sync    (sync),
            .wave    (wave[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mix <= '0;
        else
            mix <= MIX_W'(popcount(POP_W'(wave)));
    end

endmodule

// File: tb/tb_multi_tone_gen.sv
// Self-checking bench for multi_tone_gen: a cycle model feeds a scoreboard of
// expected wave/mix values, and each scenario task adds its own directed checks.
module tb_multi_tone_gen;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 12;

    logic              clk;
    logic              rst_n;
    logic              wr_valid;
    logic [1:0]        wr_addr;
    logic [CNT_W-1:0]  wr_data;
    logic [NUM_CH-1:0] ch_en;
    logic              sync;
    logic [NUM_CH-1:0] wave;
    logic [2:0]        mix;

    // Three-channel build, used for the out-of-range address case.
    logic              w3_valid;
    logic [1:0]        w3_addr;
    logic [CNT_W-1:0]  w3_data;
    logic [2:0]        en3;
    logic              sync3;
    logic [2:0]        wave3;
    logic [1:0]        mix3;

    int checks = 0;
    int errors = 0;
    string cur_test = "init";

    typedef struct {
        logic [NUM_CH-1:0] wave;
        logic [2:0]        mix;
    } exp_t;
    exp_t exp_q[$];

    logic [CNT_W-1:0]  m_sh  [NUM_CH];
    logic [CNT_W-1:0]  m_cnt [NUM_CH];
    logic [NUM_CH-1:0] m_wave;
    logic [2:0]        m_mix;

    multi_tone_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk (clk), .rst_n (rst_n), .wr_valid (wr_valid), .wr_addr (wr_addr),
        .wr_data (wr_data), .ch_en (ch_en), .sync (sync), .wave (wave), .mix (mix)
    );

    multi_tone_gen #(.NUM_CH(3), .CNT_W(CNT_W)) dut3 (
        .clk (clk), .rst_n (rst_n), .wr_valid (w3_valid), .wr_addr (w3_addr),
        .wr_data (w3_data), .ch_en (en3), .sync (sync3), .wave (wave3), .mix (mix3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: compare the post-edge DUT state against the model's prediction.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (wave !== e.wave || mix !== e.mix) begin
                    errors++;
                    $display("FAIL sb_%s: wave=%b mix=%0d expected wave=%b mix=%0d",
                             cur_test, wave, mix, e.wave, e.mix);
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_sh[i]  = '0;
            m_cnt[i] = '0;
        end
        m_wave = '0;
        m_mix  = '0;
    endtask

    task automatic model_clock();
        logic [2:0] pc;
        pc = '0;
        for (int i = 0; i < NUM_CH; i++) pc += 3'(m_wave[i]);
        for (int i = 0; i < NUM_CH; i++) begin
            if (!ch_en[i]) begin
                m_cnt[i]  = '0;
                m_wave[i] = 1'b0;
            end else if (sync) begin
                m_cnt[i]  = m_sh[i];
                m_wave[i] = 1'b0;
            end else if (m_cnt[i] != '0) begin
                m_cnt[i] = m_cnt[i] - 1'b1;
            end else begin
                m_cnt[i]  = m_sh[i];
                m_wave[i] = (m_sh[i] != '0) ? ~m_wave[i] : 1'b0;
            end
        end
        if (wr_valid && int'(wr_addr) < NUM_CH) m_sh[wr_addr] = wr_data;
        m_mix = pc;
    endtask

    // Predict the coming edge, queue it, then advance to 3 time units past that edge.
    task automatic step();
        model_clock();
        exp_q.push_back('{wave: m_wave, mix: m_mix});
        @(posedge clk);
        #3;
    endtask

    task automatic write_step(input logic [1:0] addr, input logic [CNT_W-1:0] data);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        cur_test = "reset";
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (wave !== 4'b0000 || mix !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: wave=%b mix=%0d expected 0000/0", wave, mix);
        end
        checks++;
        if (dut.g_ch[0].u_ch.cnt !== '0 || dut.g_ch[0].u_ch.shadow !== '0) begin
            errors++;
            $display("FAIL reset_state: cnt=%0d shadow=%0d expected 0/0",
                     dut.g_ch[0].u_ch.cnt, dut.g_ch[0].u_ch.shadow);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_tone();
        cur_test = "basic";
        write_step(2'd0, 12'd3);
        ch_en = 4'b0001;
        step();
        checks++;
        if (wave[0] !== 1'b1 || mix !== 3'd0) begin
            errors++;
            $display("FAIL rise_after_enable: wave0=%b mix=%0d expected 1/0", wave[0], mix);
        end
        step();
        checks++;
        if (mix !== 3'd1) begin
            errors++;
            $display("FAIL mix_lag: mix=%0d expected 1", mix);
        end
        repeat (2) step();
        checks++;
        if (wave[0] !== 1'b1) begin
            errors++;
            $display("FAIL half_period_hold: wave0=%b expected 1", wave[0]);
        end
        step();
        checks++;
        if (wave[0] !== 1'b0) begin
            errors++;
            $display("FAIL half_period_toggle: wave0=%b expected 0", wave[0]);
        end
        repeat (8) step();
    endtask

    task automatic test_period_change();
        logic [5:0] seen;
        cur_test = "period_change";
        step();
        write_step(2'd0, 12'd1);
        checks++;
        if (wave[0] !== 1'b0) begin
            errors++;
            $display("FAIL no_truncation: wave0=%b expected 0", wave[0]);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            seen[k] = wave[0];
        end
        checks++;
        if (seen !== 6'b100110) begin
            errors++;
            $display("FAIL new_period: pattern=%b expected 100110", seen);
        end
    endtask

    task automatic test_sync();
        cur_test = "sync";
        write_step(2'd0, 12'd2);
        write_step(2'd1, 12'd5);
        ch_en = 4'b0011;
        repeat (5) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++;
        if (wave[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL sync_clear: wave=%b expected xx00", wave);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 2 || k == 3) begin
                checks++;
                if (wave[0] !== (k == 3)) begin
                    errors++;
                    $display("FAIL sync_ch0_rise k=%0d: wave0=%b expected %b", k, wave[0], k == 3);
                end
            end
            if (k == 5 || k == 6) begin
                checks++;
                if (wave[1] !== (k == 6)) begin
                    errors++;
                    $display("FAIL sync_ch1_rise k=%0d: wave1=%b expected %b", k, wave[1], k == 6);
                end
            end
        end
    endtask

    task automatic test_silent();
        cur_test = "silent";
        ch_en = 4'b0000;
        step();
        for (int i = 0; i < NUM_CH; i++) write_step(2'(i), 12'd0);
        ch_en = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if (wave !== 4'b0000 || mix !== 3'd0) begin
                errors++;
                $display("FAIL silent k=%0d: wave=%b mix=%0d expected 0000/0", k, wave, mix);
            end
        end
        write_step(2'd2, 12'd4);
        step();
        checks++;
        if (wave !== 4'b0100) begin
            errors++;
            $display("FAIL wake_ch2: wave=%b expected 0100", wave);
        end
    endtask

    task automatic test_mix();
        logic [2:0] peak;
        cur_test = "mix";
        for (int i = 0; i < NUM_CH; i++) write_step(2'(i), 12'd7);
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k == 8) begin
                checks++;
                if (wave !== 4'b1111) begin
                    errors++;
                    $display("FAIL mix_all_high: wave=%b expected 1111", wave);
                end
            end
            if (k == 9 || k == 17) begin
                checks++;
                if (mix !== ((k == 9) ? 3'd4 : 3'd0)) begin
                    errors++;
                    $display("FAIL mix_level k=%0d: mix=%0d expected %0d", k, mix, (k == 9) ? 4 : 0);
                end
            end
        end
        ch_en = 4'b0111;
        step();
        checks++;
        if (wave !== 4'b0111) begin
            errors++;
            $display("FAIL drop_ch3: wave=%b expected 0111", wave);
        end
        peak = '0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (mix > peak) peak = mix;
        end
        checks++;
        if (peak !== 3'd3) begin
            errors++;
            $display("FAIL mix_peak3: peak=%0d expected 3", peak);
        end
    endtask

    task automatic test_async_reset();
        cur_test = "async_reset";
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (wave !== 4'b0000 || mix !== 3'd0) begin
            errors++;
            $display("FAIL async_outputs: wave=%b mix=%0d expected 0000/0", wave, mix);
        end
        checks++;
        if (dut.g_ch[0].u_ch.cnt !== '0 || dut.g_ch[1].u_ch.cnt !== '0 ||
            dut.g_ch[2].u_ch.cnt !== '0 || dut.g_ch[3].u_ch.cnt !== '0) begin
            errors++;
            $display("FAIL async_cnt: cnt0=%0d cnt1=%0d cnt2=%0d cnt3=%0d expected 0",
                     dut.g_ch[0].u_ch.cnt, dut.g_ch[1].u_ch.cnt,
                     dut.g_ch[2].u_ch.cnt, dut.g_ch[3].u_ch.cnt);
        end
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (10) step();
        checks++;
        if (wave !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_silent: wave=%b expected 0000", wave);
        end
    endtask

    task automatic test_addr_range();
        cur_test = "addr_range";
        en3      = 3'b111;
        w3_valid = 1'b1;
        w3_addr  = 2'd3;
        w3_data  = 12'd5;
        @(posedge clk);
        #3;
        w3_valid = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        checks++;
        if (wave3 !== 3'b000 || mix3 !== 2'd0) begin
            errors++;
            $display("FAIL oob_outputs: wave3=%b mix3=%0d expected 000/0", wave3, mix3);
        end
        checks++;
        if (dut3.g_ch[0].u_ch.shadow !== '0 || dut3.g_ch[1].u_ch.shadow !== '0 ||
            dut3.g_ch[2].u_ch.shadow !== '0) begin
            errors++;
            $display("FAIL oob_shadow: sh0=%0d sh1=%0d sh2=%0d expected 0",
                     dut3.g_ch[0].u_ch.shadow, dut3.g_ch[1].u_ch.shadow,
                     dut3.g_ch[2].u_ch.shadow);
        end
        w3_valid = 1'b1;
        w3_addr  = 2'd2;
        w3_data  = 12'd2;
        @(posedge clk);
        #3;
        w3_valid = 1'b0;
        @(posedge clk);
        #3;
        checks++;
        if (wave3 !== 3'b100) begin
            errors++;
            $display("FAIL in_range_write: wave3=%b expected 100", wave3);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        ch_en    = '0;
        sync     = 1'b0;
        w3_valid = 1'b0;
        w3_addr  = '0;
        w3_data  = '0;
        en3      = '0;
        sync3    = 1'b0;

        test_reset();
        test_basic_tone();
        test_period_change();
        test_sync();
        test_silent();
        test_mix();
        test_async_reset();
        test_addr_range();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
